// File: rtl/count_pwm_gen_pkg.sv
// Shared types and defaults for consumers of the free-running binary counter.
package count_pwm_gen_pkg;

  localparam int COUNT_W    = 8;
  localparam int PCNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Maps the raw "count below duty" comparison onto the configured polarity.
  function automatic logic pwm_level(input logic raw, input logic active_high);
    return active_high ? raw : !raw;
  endfunction

endpackage

// File: rtl/count_wrap_detect.sv
// Remembers the previous count and flags any decrease (natural wrap or upstream restart).
module count_wrap_detect
  import count_pwm_gen_pkg::*;
#(
  parameter int W = COUNT_W
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] count_i,
  output logic [W-1:0] count_q_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_i;
    end
  end

  // Equal or increasing counts never count as a wrap.
  assign wrap_o    = (count_i < count_q);
  assign count_q_o = count_q;

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator slaved to an external free-running counter; the duty value is
// double-buffered and only swapped into the comparator at period boundaries.
module count_pwm_gen
  import count_pwm_gen_pkg::*;
#(
  parameter int W           = COUNT_W,
  parameter bit ACTIVE_HIGH = 1'b1,
  parameter int PCNT_W      = PCNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [W-1:0]      count,
  input  logic [W-1:0]      duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              duty_applied,
  output logic              period_start,
  output logic              pwm_out,
  output logic              running,
  output logic [PCNT_W-1:0] period_cnt
);

  localparam logic              PWM_INACTIVE = !ACTIVE_HIGH;
  localparam logic [PCNT_W-1:0] PCNT_ONE     = PCNT_W'(1);

  state_e            state_q, state_d;
  logic [W-1:0]      shadow_q, shadow_d;
  logic [W-1:0]      active_q, active_d;
  logic              pending_q, pending_d;
  logic              pwm_q, pwm_d;
  logic              period_start_q;
  logic              duty_applied_q;
  logic [PCNT_W-1:0] period_cnt_q, period_cnt_d;

  logic         wrap;
  logic [W-1:0] count_prev;
  logic         period_upd;
  logic         apply;
  logic         accept;

  count_wrap_detect #(
    .W(W)
  ) u_wrap (
    .clk_i    (clk),
    .reset_i  (reset),
    .count_i  (count),
    .count_q_o(count_prev),
    .wrap_o   (wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!enable)   state_d = ST_IDLE;
        else if (wrap) state_d = ST_RUN;
      end
      ST_RUN:   if (!enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A period boundary counts only once running, including the wrap that starts the run.
  assign period_upd = wrap && ((state_q == ST_RUN) ||
                               (state_q == ST_ARMED && state_d == ST_RUN));
  assign apply      = period_upd && pending_q;
  assign accept     = duty_valid && !pending_q;

  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    period_cnt_d = period_cnt_q;
    pwm_d        = PWM_INACTIVE;
    if (accept) begin
      shadow_d  = duty_in;
      pending_d = 1'b1;
    end
    if (apply) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (period_upd) begin
      period_cnt_d = period_cnt_q + PCNT_ONE;
    end
    if (state_d == ST_RUN) begin
      pwm_d = pwm_level(count < active_d, ACTIVE_HIGH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= PWM_INACTIVE;
      period_start_q <= 1'b0;
      duty_applied_q <= 1'b0;
      period_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= wrap;
      duty_applied_q <= apply;
      period_cnt_q   <= period_cnt_d;
    end
  end

  assign duty_ready   = !pending_q;
  assign duty_applied = duty_applied_q;
  assign period_start = period_start_q;
  assign pwm_out      = pwm_q;
  assign running      = (state_q == ST_RUN);
  assign period_cnt   = period_cnt_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Scoreboard bench for count_pwm_gen: expected per-period results are queued up front
// and a monitor pops them as period_start and duty_applied pulses appear.
module tb_count_pwm_gen;

  typedef struct {
    int hi;
    int len;
    int pcnt;
  } win_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  count;
  logic [7:0]  duty_in;
  logic        duty_valid;
  logic        force_restart;

  logic        duty_ready, duty_applied, period_start, pwm_out, running;
  logic [15:0] period_cnt;
  logic        duty_ready_n, duty_applied_n, period_start_n, pwm_out_n, running_n;
  logic [15:0] period_cnt_n;

  win_t exp_win[$];
  int   exp_app[$];
  int   checks     = 0;
  int   errors     = 0;
  int   mirror_err = 0;

  count_pwm_gen #(.W(8), .ACTIVE_HIGH(1'b1), .PCNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .count       (count),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .duty_applied(duty_applied),
    .period_start(period_start),
    .pwm_out     (pwm_out),
    .running     (running),
    .period_cnt  (period_cnt)
  );

  count_pwm_gen #(.W(8), .ACTIVE_HIGH(1'b0), .PCNT_W(16)) dut_n (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .count       (count),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready_n),
    .duty_applied(duty_applied_n),
    .period_start(period_start_n),
    .pwm_out     (pwm_out_n),
    .running     (running_n),
    .period_cnt  (period_cnt_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream counter model: advances on the falling edge, can be forced back to 0.
  initial begin
    count = 8'd0;
    forever begin
      @(negedge clk);
      if (force_restart) count = 8'd0;
      else               count = count + 8'd1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic waitCount(input int v);
    bit hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (int'(count) == v) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) checkOutput("wait_count_timeout", 0, 1);
  endtask

  // Offers a duty value and holds it until the handshake completes.
  task automatic applyStimulus(input logic [7:0] d);
    bit done = 1'b0;
    logic ready_before;
    duty_in    = d;
    duty_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      ready_before = duty_ready;
      @(posedge clk);
      #1;
      if (ready_before) begin
        done = 1'b1;
        break;
      end
    end
    duty_valid = 1'b0;
    if (!done) checkOutput("duty_handshake_timeout", 0, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pwm"}, int'(pwm_out), 0);
    checkOutput({tag, "_pwm_inv"}, int'(pwm_out_n), 1);
    checkOutput({tag, "_duty_ready"}, int'(duty_ready), 1);
    checkOutput({tag, "_duty_applied"}, int'(duty_applied), 0);
    checkOutput({tag, "_period_start"}, int'(period_start), 0);
    checkOutput({tag, "_period_cnt"}, int'(period_cnt), 0);
    checkOutput({tag, "_running"}, int'(running), 0);
  endtask

  // Monitor: a window runs from one period_start sample up to the next one.
  initial begin : monitor
    bit   open = 1'b0;
    int   hi   = 0;
    int   len  = 0;
    bit   rst_seen;
    win_t e;
    int   ea;
    forever begin
      @(posedge clk);
      rst_seen = reset;
      #2;
      if (pwm_out_n !== ~pwm_out) mirror_err++;
      if (rst_seen) begin
        open = 1'b0;
        hi   = 0;
        len  = 0;
      end else begin
        if (period_start) begin
          if (open) begin
            if (exp_win.size() == 0) begin
              checkOutput("unexpected_window", 1, 0);
            end else begin
              e = exp_win.pop_front();
              checkOutput("window_high_cycles", hi, e.hi);
              checkOutput("window_length", len, e.len);
              checkOutput("window_period_cnt", int'(period_cnt), e.pcnt);
            end
          end
          open = 1'b1;
          hi   = 0;
          len  = 0;
        end
        if (open) begin
          len++;
          if (pwm_out) hi++;
        end
        if (duty_applied) begin
          if (exp_app.size() == 0) begin
            checkOutput("unexpected_duty_applied", 1, 0);
          end else begin
            ea = exp_app.pop_front();
            checkOutput("duty_applied_period_cnt", int'(period_cnt), ea);
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset         = 1'b1;
    enable        = 1'b0;
    duty_in       = 8'd0;
    duty_valid    = 1'b0;
    force_restart = 1'b0;

    exp_win.push_back('{hi: 64,  len: 256, pcnt: 2});
    exp_win.push_back('{hi: 64,  len: 256, pcnt: 3});
    exp_win.push_back('{hi: 0,   len: 256, pcnt: 4});
    exp_win.push_back('{hi: 255, len: 256, pcnt: 5});
    exp_win.push_back('{hi: 100, len: 256, pcnt: 6});
    exp_win.push_back('{hi: 131, len: 131, pcnt: 7});
    exp_win.push_back('{hi: 32,  len: 256, pcnt: 8});
    exp_win.push_back('{hi: 30,  len: 256, pcnt: 9});
    exp_win.push_back('{hi: 64,  len: 256, pcnt: 10});
    exp_win.push_back('{hi: 0,   len: 256, pcnt: 2});
    foreach (exp_app[i]) exp_app.delete(i);
    exp_app.push_back(1);
    exp_app.push_back(3);
    exp_app.push_back(4);
    exp_app.push_back(5);
    exp_app.push_back(6);
    exp_app.push_back(7);
    exp_app.push_back(8);

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    reset  = 1'b0;
    enable = 1'b1;
    applyStimulus(8'd64);

    waitCount(0);
    waitCount(5);
    checkOutput("running_after_first_wrap", int'(running), 1);
    checkOutput("ready_after_apply", int'(duty_ready), 1);
    waitCount(0);
    waitCount(10);
    applyStimulus(8'd0);

    waitCount(0);
    waitCount(10);
    applyStimulus(8'd255);

    waitCount(0);
    waitCount(50);
    applyStimulus(8'd100);
    checkOutput("ready_low_while_pending", int'(duty_ready), 0);
    applyStimulus(8'd200);
    checkOutput("ready_low_after_second_load", int'(duty_ready), 0);

    waitCount(0);
    waitCount(20);
    applyStimulus(8'd32);
    waitCount(130);
    force_restart = 1'b1;
    waitCount(0);
    force_restart = 1'b0;
    waitCount(10);
    applyStimulus(8'd64);

    waitCount(0);
    waitCount(29);
    enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("running_after_disable", int'(running), 0);
    checkOutput("pwm_after_disable", int'(pwm_out), 0);
    waitCount(99);
    enable = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("running_while_armed", int'(running), 0);
    waitCount(0);
    waitCount(5);
    checkOutput("running_after_rearm", int'(running), 1);

    waitCount(0);
    waitCount(5);
    applyStimulus(8'd10);
    waitCount(39);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("midrun_reset");
    reset = 1'b0;
    waitCount(0);
    waitCount(0);
    waitCount(5);

    checkOutput("windows_left_over", exp_win.size(), 0);
    checkOutput("applies_left_over", exp_app.size(), 0);
    checkOutput("inverted_mirror_cycles", mirror_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
